// File: rtl/seg7_scan_mux_if.sv
// Load-side bus of the 7-segment scan driver: value/load from the counter stage,
// pending status back to it.
interface seg7_scan_mux_if;
  logic [15:0] value;
  logic        load;
  logic        pending;

  modport master (output value, output load, input pending);
  modport slave  (input value, input load, output pending);
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous value commit.
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_mux_if.slave        bus,
  input  logic [3:0]            dp_in,
  input  logic                  blank,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [3:0]            digit_en,
  output logic                  frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   display_reg;
  logic [15:0]   pending_reg;
  logic          pending_q;
  logic          wrap_q;

  logic          tc;
  logic          wrap;
  logic [3:0]    nib;
  logic          suppress;
  logic          show;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tc          = (presc == TC);
  assign wrap        = tc && (idx == 2'd3);
  assign bus.pending = pending_q;

  always_comb begin
    nib = 4'(display_reg >> {idx, 2'b00});
`ifdef SEG7_LZ_BLANK_EN
    // a digit is a leading zero when it and every higher nibble are zero
    suppress = (idx != 2'd0) && ((display_reg >> {idx, 2'b00}) == 16'd0);
`else
    suppress = 1'b0;
`endif
    show = !blank && !suppress;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= 2'd0;
      display_reg <= 16'd0;
      pending_reg <= 16'd0;
      pending_q   <= 1'b0;
      wrap_q      <= 1'b0;
      segments    <= 7'd0;
      dp          <= 1'b0;
      digit_en    <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      presc  <= tc ? '0 : presc + CW'(1);
      if (tc) idx <= idx + 2'd1;
      wrap_q <= wrap;

      // a load landing on the wrap cycle bypasses the pending register
      if (wrap) begin
        if (bus.load)
          display_reg <= bus.value;
        else if (pending_q)
          display_reg <= pending_reg;
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_reg <= bus.value;
        pending_q   <= 1'b1;
      end

      digit_en    <= show ? (4'b0001 << idx) : 4'd0;
      segments    <= show ? hex7(nib) : 7'd0;
      dp          <= show && dp_in[idx];
      frame_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: per-cycle behavioural model plus literal pins.
module tb_seg7_scan_mux;
  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dp_in = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] digit_en;
  logic       frame_start;

  seg7_scan_mux_if bus ();

  seg7_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dp_in(dp_in), .blank(blank),
    .segments(segments), .dp(dp), .digit_en(digit_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_err = 0;

  // model state: edges since reset release, shown value, queued value
  int          n = 0;
  logic [15:0] m_disp = 16'd0;
  logic [15:0] m_preg = 16'd0;
  logic        m_pend = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs, e_pend;
  logic [3:0]  e_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_disp = 16'd0; m_preg = 16'd0; m_pend = 1'b0;
  endtask

  task automatic cycle();
    int d;
    int nb;
    logic sup, show;
    @(posedge clk);
    if (!rst_n) begin
      e_seg = 7'd0; e_dp = 1'b0; e_en = 4'd0; e_fs = 1'b0; e_pend = 1'b0;
    end else begin
      d  = (n / DIV) % 4;
      nb = int'((m_disp >> (4 * d)) & 16'hF);
`ifdef SEG7_LZ_BLANK_EN
      sup = (d > 0) && ((m_disp >> (4 * d)) == 16'd0);
`else
      sup = 1'b0;
`endif
      show  = !blank && !sup;
      e_en  = show ? 4'(1 << d) : 4'd0;
      e_seg = show ? seg_tbl[nb] : 7'd0;
      e_dp  = show && dp_in[d];
      e_fs  = (n % FR == 0) && (n >= FR);
      if (n % FR == FR - 1) begin
        if (bus.load) m_disp = bus.value;
        else if (m_pend) m_disp = m_preg;
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_preg = bus.value;
        m_pend = 1'b1;
      end
      e_pend = m_pend;
      n++;
    end
    #1;
    chk("segments", 32'(segments), 32'(e_seg));
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("pending", 32'(bus.pending), 32'(e_pend));
  endtask

  task automatic goto_phase(input int ph);
    for (int i = 0; i < 2 * FR && (n % FR) != ph; i++) cycle();
    if ((n % FR) != ph) chk("goto_phase", 32'(n % FR), 32'(ph));
  endtask

  task automatic load_once(input logic [15:0] v);
    bus.value = v; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
  endtask

  int dp_cnt;
  logic [6:0] lit_a [4];

  initial begin
    bus.value = 16'd0;
    bus.load  = 1'b0;

    // reset held
    cycle(); cycle();
    chk("reset_digit_en", 32'(digit_en), 32'h0);
    chk("reset_segments", 32'(segments), 32'h0);

    #2 rst_n = 1'b1;
    model_reset();
    cycle();
    chk("first_digit_en", 32'(digit_en), 32'h1);
    chk("first_segments", 32'(segments), 32'h3F);
    for (int i = 0; i < 40; i++) cycle();

    // mid-frame load of 1A3F
    goto_phase(5);
    load_once(16'h1A3F);
    chk("pending_after_load", 32'(bus.pending), 32'h1);
    goto_phase(0);
    lit_a = '{7'h71, 7'h4F, 7'h77, 7'h06};
    for (int d = 0; d < 4; d++) begin
      cycle();
      if (d == 0) chk("fs_1A3F", 32'(frame_start), 32'h1);
      chk("seg_1A3F", 32'(segments), 32'(lit_a[d]));
      chk("pend_clear_1A3F", 32'(bus.pending), 32'h0);
      for (int k = 1; k < DIV; k++) cycle();
    end

    // two loads in one frame: last wins
    goto_phase(3);
    load_once(16'h1111);
    goto_phase(9);
    load_once(16'h2222);
    goto_phase(0);
    for (int d = 0; d < 4; d++) begin
      cycle();
      chk("seg_2222", 32'(segments), 32'h5B);
      for (int k = 1; k < DIV; k++) cycle();
    end

    // load on the wrap cycle commits immediately
    goto_phase(FR - 1);
    load_once(16'h0008);
    chk("pend_wrap_load", 32'(bus.pending), 32'h0);
    for (int d = 0; d < 4; d++) begin
      cycle();
      if (d == 0) begin
        chk("seg_0008_d0", 32'(segments), 32'h7F);
      end else begin
`ifdef SEG7_LZ_BLANK_EN
        chk("lz_en_0008", 32'(digit_en), 32'h0);
        chk("lz_seg_0008", 32'(segments), 32'h0);
`else
        chk("seg_0008_dn", 32'(segments), 32'h3F);
`endif
      end
      for (int k = 1; k < DIV; k++) cycle();
    end

    // blank mid-slot with dp on digit 2
    load_once(16'h8421);
    goto_phase(0);
    dp_in = 4'b0100;
    goto_phase(6);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("blank_en", 32'(digit_en), 32'h0);
      chk("blank_seg", 32'(segments), 32'h0);
    end
    blank = 1'b0;
    goto_phase(0);
    dp_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      cycle();
      if (dp) begin
        dp_cnt++;
        chk("dp_slot", 32'(digit_en), 32'h4);
      end
    end
    chk("dp_count", 32'(dp_cnt), 32'(DIV));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.load  = ($urandom_range(0, 7) == 0);
      bus.value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.value = bus.value & 16'h00FF;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blank = ~blank;
      cycle();
    end
    bus.load = 1'b0;
    blank = 1'b0;
    dp_in = 4'd0;

    // reset mid-slot with a pending value
    goto_phase(6);
    load_once(16'hBEEF);
    cycle();
    chk("pend_before_rst", 32'(bus.pending), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_en", 32'(digit_en), 32'h0);
    chk("rst_async_seg", 32'(segments), 32'h0);
    chk("rst_async_pend", 32'(bus.pending), 32'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_en", 32'(digit_en), 32'h1);
    chk("post_rst_seg", 32'(segments), 32'h3F);
    for (int i = 0; i < 2 * FR; i++) begin
      cycle();
      chk("post_rst_zero", 32'(segments), 32'(digit_en == 4'h1 ? 7'h3F : 7'h0) | 32'(digit_en != 4'h1 && digit_en != 4'h0 ? 7'h3F : 7'h0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Four-digit time-multiplexed 7-segment display driver, downstream of the hex counter stage. Accepts a 16-bit value (four hex nibbles), latches it through a frame-synchronous shadow register, and scans one digit per refresh slot, driving decoded segments plus a one-hot digit enable. Updates are committed only at frame boundaries, so no frame ever shows a mix of two values.

## Interface
- REFRESH_DIV, 10000: clock cycles per digit slot; legal range ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  16  display value; nibble i drives digit i (digit 0 = value[3:0]).
- load  in  1  single-cycle strobe that captures `value` into the pending register.
- dp_in  in  4  decimal-point request per digit, sampled live, not shadowed.
- blank  in  1  forces all digit enables low while the scan keeps running.
- segments  out  7  active-high segments, bit0=a … bit6=g.
- dp  out  1  decimal point for the active digit.
- digit_en  out  4  one-hot active-high digit select.
- frame_start  out  1  one-cycle pulse when digit 0 begins a new frame.
- pending  out  1  high while a loaded value awaits commit.

## Operation
- Prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Wrap 3→0 is a frame boundary:
  - display_reg <= (load ? value : pending_reg) if (load | pending), else unchanged.
  - pending clears.
  - frame_start pulses.
- load outside a frame boundary: pending_reg <= value, pending <= 1. Repeated loads: last one wins.
- Decoding (hex): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Outputs are registered from the current index, display_reg and dp_in.
  - digit_en = one-hot(index) unless blank or the digit is suppressed; otherwise 0.
  - segments and dp are 0 whenever digit_en is 0.

## Timing
- Reset (async assert):
  - prescaler 0, index 0.
  - display_reg, pending_reg and pending 0.
  - All outputs 0.
- First rising edge after release: digit_en=0001, segments=3F.
- Output latency: one cycle from an index or display_reg change.
- Each digit is held for exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.
- frame_start is asserted in the first output cycle of digit 0, every frame. The first pulse comes after the first 3→0 wrap, not at reset release.
- Commit takes effect on the digit-0 output of the frame that frame_start marks.
- blank and dp_in take effect one cycle after they change, mid-slot included.
- Reset asserted mid-frame or mid-load: all state returns to reset values immediately, and any pending value is discarded.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero suppression.
  - Digit i (i ≥ 1) is suppressed when display_reg nibbles i..3 are all zero. Its digit_en, segments and dp stay 0 for that slot, but the slot time is still spent.
  - Digit 0 is never suppressed.
- SEG7_LZ_BLANK_EN undefined: all four digits are always shown, zeros included.

## Test plan
- Use REFRESH_DIV=4 throughout.
- Reset release, no load → digit_en cycles 0001,0010,0100,1000 every 4 cycles; segments=3F throughout; frame_start pulses every 16 cycles.
- load value=16'h1A3F mid-frame → pending=1 until the next frame_start; that frame shows segments 71,4F,77,06 for digits 0..3; pending=0 afterwards.
- load 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed (segments 5B on all digits).
- load asserted in the wrap cycle with value=16'h0008 → commits with no frame delay. Digit 0 shows 7F. Digits 1..3:
  - with SEG7_LZ_BLANK_EN: digit_en=0, segments=0.
  - without: segments 3F.
- blank=1 for 10 cycles mid-slot, dp_in=4'b0100 → digit_en=0 and segments=0 while blanked; the scan index continues; dp=1 only in the digit-2 slot.
- rst_n pulsed low mid-slot with pending=1 → outputs 0 immediately; after release, display shows 0000 and pending=0.
